// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates at period boundaries.
// Optional phase alignment of all channels via sync_i when CLK_DIV_PHASE_ALIGN_EN is defined.
module clk_div_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 2,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [DIV_W-1:0]  wr_div_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pending_o
);

`ifndef CLK_DIV_PHASE_ALIGN_EN
  logic unused_sync;
  assign unused_sync = sync_i;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             boundary;
    logic             apply;

    always_comb begin
      // Out-of-range channel indices match no channel, so such writes are dropped.
      wr_hit     = wr_en_i && (wr_ch_i == CH_W'(c));
      // A disabled channel treats every edge as a boundary so a new divisor lands at once.
      boundary   = (div_q == '0) || (cnt_q == (div_q - 1'b1));
      half       = (div_q >> 1) + DIV_W'(div_q[0]);
      div_d      = div_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;

      if (div_q != '0) begin
        clk_d  = (cnt_q < half);
        tick_d = (cnt_q == '0);
        cnt_d  = boundary ? '0 : (cnt_q + 1'b1);
      end

      apply = boundary;
`ifdef CLK_DIV_PHASE_ALIGN_EN
      if (sync_i && (div_q != '0)) begin
        apply = 1'b1;
      end
`endif

      if (apply) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pend_val_q;
          pend_d = 1'b0;
        end
      end

      // A write on the applying edge stays pending for the following boundary.
      if (wr_hit) begin
        pend_d     = 1'b1;
        pend_val_d = wr_div_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n) begin
        div_q      <= DIV_W'(RESET_DIV);
        cnt_q      <= '0;
        pend_q     <= 1'b0;
        pend_val_q <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        div_q      <= div_d;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        pend_val_q <= pend_val_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_o[c]     = clk_q;
    assign tick_o[c]    = tick_q;
    assign pending_o[c] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (NUM_CH=4, DIV_W=16, RESET_DIV=2).
module tb_clk_div_multi;

  logic        clk_i;
  logic        reset_n;
  logic        wr_en_i;
  logic [1:0]  wr_ch_i;
  logic [15:0] wr_div_i;
  logic        sync_i;
  logic [3:0]  clk_o;
  logic [3:0]  tick_o;
  logic [3:0]  pending_o;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH   (4),
    .DIV_W    (16),
    .RESET_DIV(2)
  ) dut (
    .clk_i    (clk_i),
    .reset_n  (reset_n),
    .wr_en_i  (wr_en_i),
    .wr_ch_i  (wr_ch_i),
    .wr_div_i (wr_div_i),
    .sync_i   (sync_i),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .pending_o(pending_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] v);
    wr_en_i  = 1'b1;
    wr_ch_i  = ch;
    wr_div_i = v;
    step();
    wr_en_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    reset_n  = 1'b0;
    wr_en_i  = 1'b1;
    wr_ch_i  = 2'd0;
    wr_div_i = 16'd7;
    sync_i   = 1'b0;
    step();
    step();
    checks++;
    if (clk_o !== 4'h0) begin errors++; $display("FAIL reset_clk got %h want 0", clk_o); end
    checks++;
    if (tick_o !== 4'h0) begin errors++; $display("FAIL reset_tick got %h want 0", tick_o); end
    checks++;
    if (pending_o !== 4'h0) begin
      errors++; $display("FAIL reset_pending got %h want 0", pending_o);
    end
    wr_en_i = 1'b0;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      e = (i % 2 == 1) ? 4'hF : 4'h0;
      checks++;
      if (clk_o !== e) begin errors++; $display("FAIL release_clk%0d got %h want %h", i, clk_o, e); end
      checks++;
      if (tick_o !== e) begin errors++; $display("FAIL release_tick%0d got %h want %h", i, tick_o, e); end
    end
  endtask

  task automatic test_div5();
    logic [3:0] ec, et;
    logic       o;
    do_write(2'd1, 16'd5);
    checks++;
    if (pending_o !== 4'b0010) begin
      errors++; $display("FAIL div5_pend_set got %h want 2", pending_o);
    end
    checks++;
    if (clk_o !== 4'hF) begin errors++; $display("FAIL div5_clk_w got %h want f", clk_o); end
    step();
    checks++;
    if (pending_o !== 4'h0) begin
      errors++; $display("FAIL div5_pend_clr got %h want 0", pending_o);
    end
    checks++;
    if (clk_o !== 4'h0) begin errors++; $display("FAIL div5_clk_b got %h want 0", clk_o); end
    for (int k = 0; k < 10; k++) begin
      step();
      o  = (k % 2 == 0);
      ec = {o, o, ((k % 5) < 3), o};
      et = {o, o, ((k % 5) == 0), o};
      checks++;
      if (clk_o !== ec) begin errors++; $display("FAIL div5_clk%0d got %h want %h", k, clk_o, ec); end
      checks++;
      if (tick_o !== et) begin errors++; $display("FAIL div5_tick%0d got %h want %h", k, tick_o, et); end
    end
  endtask

  task automatic test_disable();
    do_write(2'd2, 16'd0);
    checks++;
    if (pending_o !== 4'b0100) begin
      errors++; $display("FAIL dis_pend_set got %h want 4", pending_o);
    end
    step();
    checks++;
    if (pending_o !== 4'h0 || clk_o[2] !== 1'b0) begin
      errors++; $display("FAIL dis_apply got pend %h clk2 %b want 0 0", pending_o, clk_o[2]);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (clk_o[2] !== 1'b0 || tick_o[2] !== 1'b0) begin
        errors++; $display("FAIL dis_low%0d got clk %b tick %b want 0 0", k, clk_o[2], tick_o[2]);
      end
    end
    do_write(2'd2, 16'd3);
    checks++;
    if (pending_o !== 4'b0100 || clk_o[2] !== 1'b0) begin
      errors++; $display("FAIL en_wr got pend %h clk2 %b want 4 0", pending_o, clk_o[2]);
    end
    step();
    checks++;
    if (pending_o !== 4'h0 || clk_o[2] !== 1'b0 || tick_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL en_act got pend %h clk2 %b tick2 %b want 0 0 0", pending_o, clk_o[2], tick_o[2]);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (clk_o[2] !== ((k % 3) < 2) || tick_o[2] !== ((k % 3) == 0)) begin
        errors++;
        $display("FAIL en_div3_%0d got clk %b tick %b want %b %b", k, clk_o[2], tick_o[2],
                 ((k % 3) < 2), ((k % 3) == 0));
      end
    end
  endtask

  task automatic test_boundary_write();
    do_write(2'd3, 16'd7);
    checks++;
    if (pending_o !== 4'b1000) begin
      errors++; $display("FAIL bw_pend7 got %h want 8", pending_o);
    end
    do_write(2'd3, 16'd4);
    checks++;
    if (pending_o !== 4'b1000 || clk_o[3] !== 1'b0) begin
      errors++; $display("FAIL bw_hold got pend %h clk3 %b want 8 0", pending_o, clk_o[3]);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (clk_o[3] !== (k < 4) || tick_o[3] !== (k == 0) || pending_o[3] !== (k < 6)) begin
        errors++;
        $display("FAIL bw_div7_%0d got clk %b tick %b pend %b want %b %b %b", k, clk_o[3],
                 tick_o[3], pending_o[3], (k < 4), (k == 0), (k < 6));
      end
    end
    step();
    checks++;
    if (clk_o[3] !== 1'b1 || tick_o[3] !== 1'b1) begin
      errors++; $display("FAIL bw_div4_start got clk %b tick %b want 1 1", clk_o[3], tick_o[3]);
    end
  endtask

  task automatic test_overwrite();
    do_write(2'd3, 16'd6);
    checks++;
    if (pending_o !== 4'b1000 || clk_o[3] !== 1'b1 || tick_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL ow_first got pend %h clk3 %b tick3 %b want 8 1 0", pending_o, clk_o[3],
               tick_o[3]);
    end
    do_write(2'd3, 16'd3);
    checks++;
    if (pending_o !== 4'b1000 || clk_o[3] !== 1'b0) begin
      errors++; $display("FAIL ow_second got pend %h clk3 %b want 8 0", pending_o, clk_o[3]);
    end
    step();
    checks++;
    if (pending_o !== 4'h0 || clk_o[3] !== 1'b0) begin
      errors++; $display("FAIL ow_apply got pend %h clk3 %b want 0 0", pending_o, clk_o[3]);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (clk_o[3] !== ((k % 3) < 2) || tick_o[3] !== ((k % 3) == 0)) begin
        errors++;
        $display("FAIL ow_div3_%0d got clk %b tick %b want %b %b", k, clk_o[3], tick_o[3],
                 ((k % 3) < 2), ((k % 3) == 0));
      end
    end
  endtask

  task automatic test_sync();
    logic [3:0] et, ec;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    et = 4'hF;
    ec = 4'hF;
`else
    et = 4'h0;
    ec = 4'b0110;
`endif
    step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    step();
    checks++;
    if (tick_o !== et) begin errors++; $display("FAIL sync_tick got %h want %h", tick_o, et); end
    checks++;
    if (clk_o !== ec) begin errors++; $display("FAIL sync_clk got %h want %h", clk_o, ec); end
  endtask

  task automatic test_reset_mid();
    do_write(2'd1, 16'd9);
    for (int k = 0; k < 5; k++) step();
    do_write(2'd1, 16'd4);
    checks++;
    if (pending_o[1] !== 1'b1) begin
      errors++; $display("FAIL rm_pend got %b want 1", pending_o[1]);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (clk_o !== 4'h0 || tick_o !== 4'h0 || pending_o !== 4'h0) begin
      errors++;
      $display("FAIL rm_reset got clk %h tick %h pend %h want 0 0 0", clk_o, tick_o, pending_o);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (clk_o !== 4'hF || tick_o !== 4'hF) begin
      errors++; $display("FAIL rm_first got clk %h tick %h want f f", clk_o, tick_o);
    end
    step();
    checks++;
    if (clk_o !== 4'h0 || pending_o !== 4'h0) begin
      errors++; $display("FAIL rm_div2 got clk %h pend %h want 0 0", clk_o, pending_o);
    end
    step();
    checks++;
    if (clk_o !== 4'hF || tick_o !== 4'hF) begin
      errors++; $display("FAIL rm_third got clk %h tick %h want f f", clk_o, tick_o);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en_i  = 1'b0;
    wr_ch_i  = 2'd0;
    wr_div_i = 16'd0;
    sync_i   = 1'b0;
    test_reset();
    test_div5();
    test_disable();
    test_boundary_write();
    test_overwrite();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
